// File: rtl/fb_pkg.sv
// Shared types and constants for the vsync-aligned framebuffer page flipper.
// The FB_SWAP_IRQ_EN macro (optional flip interrupt) is consumed by fb_page_flip_if and fb_page_flip.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2,
    ACK     = 2'd3
  } fb_state_e;

  localparam int FB_CTRL_FULL_BIT = 0;
  localparam int FB_CTRL_EN_BIT   = 1;

  // fb_status layout: {frame_cnt[15:0], 11'b0, state[1:0], front_idx, pending, EN}
  localparam int FB_STAT_EN_BIT    = 0;
  localparam int FB_STAT_PEND_BIT  = 1;
  localparam int FB_STAT_FRONT_BIT = 2;
  localparam int FB_STAT_STATE_LSB = 3;
  localparam int FB_STAT_FCNT_LSB  = 16;

  localparam logic [31:0] FB_BUF0_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] FB_BUF1_BASE_DEF = 32'h3040_0000;

endpackage

// File: rtl/fb_page_flip_if.sv
// Control/status bundle between the fb_full PIO, scanout DMA and the page flipper.
// irq is present only when FB_SWAP_IRQ_EN is defined.
interface fb_page_flip_if;
  logic [31:0] fb_full;
  logic        vsync;
  logic [31:0] front_base;
  logic [31:0] back_base;
  logic        swap_done;
  logic [31:0] fb_status;
`ifdef FB_SWAP_IRQ_EN
  logic        irq;

  modport master (output fb_full, vsync,
                  input  front_base, back_base, swap_done, fb_status, irq);
  modport slave  (input  fb_full, vsync,
                  output front_base, back_base, swap_done, fb_status, irq);
`else
  modport master (output fb_full, vsync,
                  input  front_base, back_base, swap_done, fb_status);
  modport slave  (input  fb_full, vsync,
                  output front_base, back_base, swap_done, fb_status);
`endif
endinterface

// File: rtl/fb_edge_det.sv
// Rising-edge detector: registers the input and flags 0->1 transitions.
module fb_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: registered state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/fb_page_flip.sv
// Vsync-aligned double-buffer page flipper driven by the SW fb_full control word.
// Define FB_SWAP_IRQ_EN to add an irq output raised on each flip until SW drops FULL.
module fb_page_flip
  import fb_pkg::*;
#(
  parameter logic [31:0] BUF0_BASE = FB_BUF0_BASE_DEF,
  parameter logic [31:0] BUF1_BASE = FB_BUF1_BASE_DEF,
  parameter int          FCNT_W    = 16
) (
  input logic           clk,
  input logic           reset_n,
  fb_page_flip_if.slave bus
);

  fb_state_e         state, state_nxt;
  logic              full, en, full_rise, vs_start;
  logic              front_idx, en_q;
  logic [31:0]       front_q, back_q;
  logic [FCNT_W-1:0] frame_cnt;
  logic              ctrl_unused;

  assign full        = bus.fb_full[FB_CTRL_FULL_BIT];
  assign en          = bus.fb_full[FB_CTRL_EN_BIT];
  assign ctrl_unused = ^bus.fb_full[31:2];

  fb_edge_det u_full_edge (.clk(clk), .reset_n(reset_n), .d(full),      .rise(full_rise));
  fb_edge_det u_vs_edge   (.clk(clk), .reset_n(reset_n), .d(bus.vsync), .rise(vs_start));

  // NOTE: the default assignment first means no path leaves state_nxt unassigned, so no latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && full_rise) state_nxt = PENDING;
      PENDING: if (!en)             state_nxt = IDLE;
               else if (vs_start)   state_nxt = SWAP;
      SWAP:                         state_nxt = ACK;
      ACK:     if (!full)           state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      front_idx <= 1'b0;
      front_q   <= BUF0_BASE;
      back_q    <= BUF1_BASE;
      frame_cnt <= '0;
      en_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      en_q  <= en;
      if (vs_start) frame_cnt <= frame_cnt + 1'b1;
      // The exchange lands at the end of SWAP, so the DMA sees the new front next cycle.
      if (state == SWAP) begin
        front_idx <= ~front_idx;
        front_q   <= back_q;
        back_q    <= front_q;
      end
    end
  end

`ifdef FB_SWAP_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            irq_q <= 1'b0;
    else if (state_nxt == SWAP)              irq_q <= 1'b1;
    else if (state == ACK && state_nxt == IDLE) irq_q <= 1'b0;
  end

  assign bus.irq = irq_q;
`endif

  assign bus.front_base = front_q;
  assign bus.back_base  = back_q;
  assign bus.swap_done  = (state == SWAP);

  always_comb begin
    bus.fb_status                              = '0;
    bus.fb_status[FB_STAT_FCNT_LSB +: 16]      = 16'(frame_cnt);
    bus.fb_status[FB_STAT_STATE_LSB +: 2]      = state;
    bus.fb_status[FB_STAT_FRONT_BIT]           = front_idx;
    bus.fb_status[FB_STAT_PEND_BIT]            = (state == PENDING);
    bus.fb_status[FB_STAT_EN_BIT]              = en_q;
  end

endmodule

// File: tb/tb_fb_page_flip.sv
// Scoreboard bench for fb_page_flip: directed flip scenarios plus randomized SW/vsync traffic
// against an event-level reference model of the flip protocol.
`timescale 1ns/1ps
module tb_fb_page_flip;

  localparam logic [31:0] B0 = 32'h3000_0000;
  localparam logic [31:0] B1 = 32'h3040_0000;
  localparam int          FW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_page_flip_if bus ();

  fb_page_flip #(.BUF0_BASE(B0), .BUF1_BASE(B1), .FCNT_W(FW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_no;
    logic [31:0] front;
    int          fcnt;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: SW request armed -> flip on a later vsync rise -> wait for SW ack.
  bit m_full_prev, m_vs_prev, m_armed, m_in_swap, m_ack_wait, m_front, m_en;
  int m_fcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] base_of(input bit idx);
    return idx ? B1 : B0;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [1:0] st;
    st = m_in_swap ? 2'd2 : m_ack_wait ? 2'd3 : m_armed ? 2'd1 : 2'd0;
    return {16'(m_fcnt), 11'b0, st, m_front, m_armed, m_en};
  endfunction

  task automatic model_reset();
    m_full_prev = 0; m_vs_prev = 0; m_armed = 0; m_in_swap = 0;
    m_ack_wait = 0; m_front = 0; m_en = 0; m_fcnt = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model past the coming edge, then wait for it.
  task automatic step(input bit full, input bit en, input bit vs);
    bit full_rise, vs_rise;
    bus.fb_full = {30'h0, en, full};
    bus.vsync   = vs;
    full_rise = full && !m_full_prev;
    vs_rise   = vs && !m_vs_prev;
    if (vs_rise) m_fcnt = (m_fcnt + 1) % (1 << FW);
    if (m_in_swap) begin
      m_in_swap = 0; m_ack_wait = 1; m_front = ~m_front;
    end else if (m_ack_wait) begin
      if (!full) m_ack_wait = 0;
    end else if (m_armed) begin
      if (!en) m_armed = 0;
      else if (vs_rise) begin
        m_armed = 0; m_in_swap = 1;
        sb_q.push_back('{edge_no: cyc + 1, front: base_of(!m_front), fcnt: m_fcnt});
      end
    end else if (en && full_rise) begin
      m_armed = 1;
    end
    m_full_prev = full; m_vs_prev = vs; m_en = en;
    @(posedge clk); #1;
  endtask

  // Monitor: every swap_done pulse must match the next queued flip.
  initial begin : monitor
    bit          front_chk;
    logic [31:0] exp_front;
    exp_t        e;
    front_chk = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        front_chk = 0;
      end else begin
        if (front_chk) begin
          check("front_after_swap", bus.front_base, exp_front);
          check("back_after_swap", bus.back_base, (exp_front == B0) ? B1 : B0);
          front_chk = 0;
        end
        if (bus.swap_done) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_swap: swap_done=1 at cycle %0d, none expected", cyc);
          end else begin
            e = sb_q.pop_front();
            check("swap_cycle", cyc, e.edge_no);
            check("swap_fcnt", {16'h0, bus.fb_status[31:16]}, e.fcnt);
`ifdef FB_SWAP_IRQ_EN
            check("irq_on_swap", {31'h0, bus.irq}, 32'h1);
`endif
            exp_front = e.front;
            front_chk = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0, vs_cnt;
    bit full, en, vs;
    bus.fb_full = '0;
    bus.vsync   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_front", bus.front_base, B0);
    check("rst_back", bus.back_base, B1);
    check("rst_swap_done", {31'h0, bus.swap_done}, 32'h0);
    check("rst_status", bus.fb_status, 32'h0);
`ifdef FB_SWAP_IRQ_EN
    check("rst_irq", {31'h0, bus.irq}, 32'h0);
`endif
    reset_n = 1'b1;

    // 1: arm, vsync three cycles later -> single flip to buffer 1, state ACK
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(1, 1, 0);
    step(1, 1, 1);
    repeat (3) step(1, 1, 0);
    check("t1_front", bus.front_base, 32'h3040_0000);
    check("t1_state_ack", {30'h0, bus.fb_status[4:3]}, 32'h3);
    check("t1_status", bus.fb_status, exp_status());

    // 3: FULL held through three vsyncs never re-arms; drop -> IDLE; re-arm flips back
    repeat (3) begin step(1, 1, 1); step(1, 1, 0); step(1, 1, 0); end
    check("t3_still_ack", {30'h0, bus.fb_status[4:3]}, 32'h3);
    step(0, 1, 0);
    step(0, 1, 0);
    check("t3_idle", {30'h0, bus.fb_status[4:3]}, 32'h0);
`ifdef FB_SWAP_IRQ_EN
    check("t3_irq_clr", {31'h0, bus.irq}, 32'h0);
`endif
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
    check("t3_front_back", bus.front_base, 32'h3000_0000);
    step(0, 1, 0); step(0, 1, 0);

    // 2: FULL and vsync rise together -> armed but flips only on the next vsync
    f0 = m_fcnt;
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    check("t2_pending", bus.fb_status, exp_status());
    check("t2_pend_bit", {31'h0, bus.fb_status[1]}, 32'h1);
    step(1, 1, 1);
    step(1, 1, 0); step(1, 1, 0);
    check("t2_fcnt", {16'h0, bus.fb_status[31:16]}, (f0 + 2) % (1 << FW));
    step(0, 1, 0); step(0, 1, 0);

    // 4: EN drops while pending -> cancel, no flip on the following vsync
    step(1, 1, 0);
    check("t4_pending", {30'h0, bus.fb_status[4:3]}, 32'h1);
    step(1, 0, 0);
    check("t4_idle", {30'h0, bus.fb_status[4:3]}, 32'h0);
    step(1, 0, 1); step(1, 0, 0);
    check("t4_front", bus.front_base, base_of(m_front));
    check("t4_status", bus.fb_status, exp_status());
    step(0, 1, 0);

    // 5: asynchronous reset while pending
    step(1, 1, 0);
    check("t5_pending", {30'h0, bus.fb_status[4:3]}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_front", bus.front_base, B0);
    check("t5_back", bus.back_base, B1);
    check("t5_swap_done", {31'h0, bus.swap_done}, 32'h0);
    check("t5_status", bus.fb_status & 32'hFFFF_FFFE, 32'h0);
    bus.fb_full = '0;
    bus.vsync   = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Frame counter wrap at 2^FW vsyncs, independent of EN
    repeat (1 << FW) begin step(0, 0, 1); step(0, 0, 0); end
    check("wrap_zero", {16'h0, bus.fb_status[31:16]}, 32'h0);
    repeat (3) begin step(0, 0, 1); step(0, 0, 0); end
    check("wrap_three", {16'h0, bus.fb_status[31:16]}, 32'h3);

    // Randomized SW/vsync traffic, full status compared every cycle
    full = 0; en = 1; vs = 0; vs_cnt = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) full = ~full;
      en = ($urandom_range(0, 19) != 0);
      if (vs_cnt == 0) begin
        vs = ~vs;
        vs_cnt = vs ? $urandom_range(0, 2) : $urandom_range(1, 8);
      end else begin
        vs_cnt--;
      end
      step(full, en, vs);
      check("rand_status", bus.fb_status, exp_status());
      check("rand_front", bus.front_base, base_of(m_front));
    end

    repeat (8) step(0, 1, 0);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
